// File: rtl/checked_stack_pkg.sv
// Shared constants and request decoding for the checked stack.
// The opcode folds the three request lines into one value with clr taking priority.
package checked_stack_pkg;

  localparam int DEFAULT_WIDTH     = 16;
  localparam int DEFAULT_DEPTHLOG2 = 3;

  typedef enum logic [2:0] {
    NOP,
    PUSH,
    POP,
    REPL,
    CLR
  } op_e;

  // push and pop together mean "replace top"; clr overrides everything.
  function automatic op_e decode_op(input logic clr_i, input logic push_i, input logic pop_i);
    op_e op;
    op = NOP;
    if (clr_i) begin
      op = CLR;
    end else if (push_i && pop_i) begin
      op = REPL;
    end else if (push_i) begin
      op = PUSH;
    end else if (pop_i) begin
      op = POP;
    end
    return op;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// Stack storage: one synchronous write port, two asynchronous read ports.
// Contents are deliberately not reset.
module stack_ram #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/checked_stack.sv
// Stack with registered top/next-on-stack, occupancy count and sticky error flags.
// WRAP=1 behaves as a circular J1-style stack; WRAP=0 refuses overflow/underflow.
module checked_stack
  import checked_stack_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTHLOG2 = DEFAULT_DEPTHLOG2,
  parameter int WRAP      = 1
) (
  input  logic                 clk,
  input  logic                 resetq,
  input  logic [WIDTH-1:0]     in,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 clr,
  input  logic                 err_clr,
  output logic [WIDTH-1:0]     tos,
  output logic [WIDTH-1:0]     nos,
  output logic [DEPTHLOG2:0]   count,
  output logic                 empty,
  output logic                 full,
  output logic                 ovf,
  output logic                 unf
);

  localparam int DEPTH = 2**DEPTHLOG2;
  localparam logic [DEPTHLOG2:0]   CNT_ZERO  = '0;
  localparam logic [DEPTHLOG2:0]   CNT_ONE   = (DEPTHLOG2+1)'(1);
  localparam logic [DEPTHLOG2:0]   CNT_THREE = (DEPTHLOG2+1)'(3);
  localparam logic [DEPTHLOG2:0]   CNT_FULL  = (DEPTHLOG2+1)'(DEPTH);
  localparam logic [DEPTHLOG2-1:0] PTR_ONE   = DEPTHLOG2'(1);
  localparam logic [DEPTHLOG2-1:0] PTR_TWO   = DEPTHLOG2'(2);
  localparam logic [DEPTHLOG2-1:0] PTR_THREE = DEPTHLOG2'(3);

  // ptr_q is the next free slot; the top entry lives at ptr_q-1.
  logic [DEPTHLOG2-1:0] ptr_q, ptr_d;
  logic [DEPTHLOG2:0]   count_q, count_d;
  logic [WIDTH-1:0]     tos_q, tos_d;
  logic [WIDTH-1:0]     nos_q, nos_d;
  logic                 empty_q, empty_d;
  logic                 full_q, full_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic                 run_q;

  logic                 ovf_set;
  logic                 unf_set;
  logic                 ram_we;
  logic [DEPTHLOG2-1:0] ram_waddr;
  logic [WIDTH-1:0]     rd_a;
  logic [WIDTH-1:0]     rd_b;
  logic                 err_clr_g;
  op_e                  op;

  // run_q stays low through the edge on which reset releases, so a request
  // coinciding with that edge can never take effect.
  assign op        = run_q ? decode_op(clr, push, pop) : NOP;
  assign err_clr_g = run_q & err_clr;

  stack_ram #(
    .WIDTH (WIDTH),
    .AW    (DEPTHLOG2)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (in),
    .raddr_a (ptr_q - PTR_TWO),
    .rdata_a (rd_a),
    .raddr_b (ptr_q - PTR_THREE),
    .rdata_b (rd_b)
  );

  always_comb begin
    ptr_d     = ptr_q;
    count_d   = count_q;
    tos_d     = tos_q;
    nos_d     = nos_q;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = ptr_q;

    case (op)
      CLR: begin
        ptr_d   = '0;
        count_d = CNT_ZERO;
        tos_d   = '0;
        nos_d   = '0;
      end

      PUSH: begin
        if (!full_q) begin
          ram_we  = 1'b1;
          ptr_d   = ptr_q + PTR_ONE;
          count_d = count_q + CNT_ONE;
          tos_d   = in;
          nos_d   = tos_q;
        end else begin
          ovf_set = 1'b1;
          // Circular mode: the slot at ptr_q is the oldest entry, overwrite it.
          if (WRAP != 0) begin
            ram_we = 1'b1;
            ptr_d  = ptr_q + PTR_ONE;
            tos_d  = in;
            nos_d  = tos_q;
          end
        end
      end

      POP: begin
        if (!empty_q) begin
          ptr_d   = ptr_q - PTR_ONE;
          count_d = count_q - CNT_ONE;
          tos_d   = nos_q;
          if ((WRAP != 0) || (count_q >= CNT_THREE)) begin
            nos_d = rd_b;
          end else begin
            nos_d = '0;
          end
        end else begin
          unf_set = 1'b1;
          if (WRAP != 0) begin
            ptr_d = ptr_q - PTR_ONE;
            tos_d = rd_a;
            nos_d = rd_b;
          end
        end
      end

      REPL: begin
        unf_set = empty_q;
        if (!empty_q || (WRAP != 0)) begin
          ram_we    = 1'b1;
          ram_waddr = ptr_q - PTR_ONE;
          tos_d     = in;
        end
      end

      default: begin
      end
    endcase

    // A fresh error beats a simultaneous clear request.
    ovf_d   = ovf_set | (ovf_q & ~err_clr_g);
    unf_d   = unf_set | (unf_q & ~err_clr_g);
    empty_d = (count_d == CNT_ZERO);
    full_d  = (count_d == CNT_FULL);
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      run_q   <= 1'b0;
      ptr_q   <= '0;
      count_q <= CNT_ZERO;
      tos_q   <= '0;
      nos_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      tos_q   <= tos_d;
      nos_q   <= nos_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign tos   = tos_q;
  assign nos   = nos_q;
  assign count = count_q;
  assign empty = empty_q;
  assign full  = full_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_checked_stack.sv
// Directed bench for checked_stack: a guarded instance (index 0) and a circular
// instance (index 1), driven independently from one table plus reset sequences.
module tb_checked_stack;

  localparam int G = 0;
  localparam int W = 1;

  logic        clk    = 1'b0;
  logic        resetq = 1'b1;

  logic [15:0] in_s      [2];
  logic        push_s    [2];
  logic        pop_s     [2];
  logic        clr_s     [2];
  logic        err_clr_s [2];
  logic [15:0] tos_s     [2];
  logic [15:0] nos_s     [2];
  logic [3:0]  cnt_s     [2];
  logic        empty_s   [2];
  logic        full_s    [2];
  logic        ovf_s     [2];
  logic        unf_s     [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  checked_stack #(.WIDTH(16), .DEPTHLOG2(3), .WRAP(0)) u_grd (
    .clk(clk), .resetq(resetq), .in(in_s[G]), .push(push_s[G]), .pop(pop_s[G]),
    .clr(clr_s[G]), .err_clr(err_clr_s[G]), .tos(tos_s[G]), .nos(nos_s[G]),
    .count(cnt_s[G]), .empty(empty_s[G]), .full(full_s[G]), .ovf(ovf_s[G]), .unf(unf_s[G])
  );

  checked_stack #(.WIDTH(16), .DEPTHLOG2(3), .WRAP(1)) u_wrap (
    .clk(clk), .resetq(resetq), .in(in_s[W]), .push(push_s[W]), .pop(pop_s[W]),
    .clr(clr_s[W]), .err_clr(err_clr_s[W]), .tos(tos_s[W]), .nos(nos_s[W]),
    .count(cnt_s[W]), .empty(empty_s[W]), .full(full_s[W]), .ovf(ovf_s[W]), .unf(unf_s[W])
  );

  typedef struct {
    int          sel;
    logic        push;
    logic        pop;
    logic        clr;
    logic        eclr;
    logic [15:0] din;
    logic [39:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [39:0] ex(logic [15:0] t, logic [15:0] n, logic [3:0] c,
                                     logic e, logic f, logic o, logic u);
    return {t, n, c, e, f, o, u};
  endfunction

  function automatic vec_t row(int s, logic pu, logic po, logic cl, logic ec,
                               logic [15:0] d, logic [39:0] e, string nm);
    vec_t v;
    v.sel  = s;
    v.push = pu;
    v.pop  = po;
    v.clr  = cl;
    v.eclr = ec;
    v.din  = d;
    v.exp  = e;
    v.name = nm;
    return v;
  endfunction

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      in_s[i]      = 16'h0000;
      push_s[i]    = 1'b0;
      pop_s[i]     = 1'b0;
      clr_s[i]     = 1'b0;
      err_clr_s[i] = 1'b0;
    end
  endtask

  task automatic check(int s, string nm, logic [39:0] exp);
    logic [39:0] act;
    act = {tos_s[s], nos_s[s], cnt_s[s], empty_s[s], full_s[s], ovf_s[s], unf_s[s]};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got tos=%h nos=%h count=%0d empty=%b full=%b ovf=%b unf=%b, expected tos=%h nos=%h count=%0d empty=%b full=%b ovf=%b unf=%b",
               nm, s, act[39:24], act[23:8], act[7:4], act[3], act[2], act[1], act[0],
               exp[39:24], exp[23:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end else begin
      $display("ok   %s dut%0d: tos=%h nos=%h count=%0d empty=%b full=%b ovf=%b unf=%b",
               nm, s, act[39:24], act[23:8], act[7:4], act[3], act[2], act[1], act[0]);
    end
  endtask

  // One request on one edge: drive after the falling edge, sample 1 ns after the rising edge.
  task automatic drive(int s, logic pu, logic po, logic cl, logic ec, logic [15:0] d);
    @(negedge clk);
    idle_inputs();
    in_s[s]      = d;
    push_s[s]    = pu;
    pop_s[s]     = po;
    clr_s[s]     = cl;
    err_clr_s[s] = ec;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();

    // ---------------- circular instance ----------------
    vecs.push_back(row(W, 1, 0, 0, 0, 16'h1111, ex(16'h1111, 16'h0000, 4'd1, 0, 0, 0, 0), "w_push1"));
    vecs.push_back(row(W, 1, 0, 0, 0, 16'h2222, ex(16'h2222, 16'h1111, 4'd2, 0, 0, 0, 0), "w_push2"));
    vecs.push_back(row(W, 1, 0, 0, 0, 16'h3333, ex(16'h3333, 16'h2222, 4'd3, 0, 0, 0, 0), "w_push3"));
    vecs.push_back(row(W, 0, 1, 0, 0, 16'h0000, ex(16'h2222, 16'h1111, 4'd2, 0, 0, 0, 0), "w_pop"));
    vecs.push_back(row(W, 0, 0, 1, 0, 16'h0000, ex(16'h0000, 16'h0000, 4'd0, 1, 0, 0, 0), "w_clr"));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(row(W, 1, 0, 0, 0, 16'(k),
                         ex(16'(k), 16'(k-1), 4'(k), 1'b0, (k == 8), 1'b0, 1'b0), "w_fill"));
    vecs.push_back(row(W, 1, 0, 0, 0, 16'd9, ex(16'd9, 16'd8, 4'd8, 0, 1, 1, 0), "w_push_full"));
    for (int k = 1; k <= 8; k++) begin
      logic [15:0] t;
      logic [15:0] n;
      t = (k == 8) ? 16'd9 : 16'(9 - k);
      n = (k == 8) ? 16'd8 : ((k == 7) ? 16'd9 : 16'(8 - k));
      vecs.push_back(row(W, 0, 1, 0, 0, 16'h0000,
                         ex(t, n, 4'(8 - k), (k == 8), 1'b0, 1'b1, 1'b0), "w_drain"));
    end
    vecs.push_back(row(W, 0, 1, 0, 0, 16'h0000, ex(16'd8, 16'd7, 4'd0, 1, 0, 1, 1), "w_pop_empty"));
    vecs.push_back(row(W, 0, 0, 0, 1, 16'h0000, ex(16'd8, 16'd7, 4'd0, 1, 0, 0, 0), "w_errclr"));
    vecs.push_back(row(W, 1, 1, 0, 0, 16'hDDDD, ex(16'hDDDD, 16'd7, 4'd0, 1, 0, 0, 1), "w_repl_empty"));
    vecs.push_back(row(W, 0, 0, 0, 1, 16'h0000, ex(16'hDDDD, 16'd7, 4'd0, 1, 0, 0, 0), "w_errclr2"));
    vecs.push_back(row(W, 0, 0, 0, 0, 16'hFFFF, ex(16'hDDDD, 16'd7, 4'd0, 1, 0, 0, 0), "w_nop"));
    vecs.push_back(row(W, 0, 0, 1, 0, 16'h0000, ex(16'h0000, 16'h0000, 4'd0, 1, 0, 0, 0), "w_clr2"));
    vecs.push_back(row(W, 1, 0, 0, 0, 16'hAAAA, ex(16'hAAAA, 16'h0000, 4'd1, 0, 0, 0, 0), "w_push_a"));
    vecs.push_back(row(W, 1, 0, 0, 0, 16'hBBBB, ex(16'hBBBB, 16'hAAAA, 4'd2, 0, 0, 0, 0), "w_push_b"));
    vecs.push_back(row(W, 1, 1, 0, 0, 16'hCCCC, ex(16'hCCCC, 16'hAAAA, 4'd2, 0, 0, 0, 0), "w_repl_c"));
    vecs.push_back(row(W, 1, 0, 1, 0, 16'h1234, ex(16'h0000, 16'h0000, 4'd0, 1, 0, 0, 0), "w_clr_push"));

    // ---------------- guarded instance ----------------
    for (int k = 1; k <= 8; k++)
      vecs.push_back(row(G, 1, 0, 0, 0, 16'(k),
                         ex(16'(k), 16'(k-1), 4'(k), 1'b0, (k == 8), 1'b0, 1'b0), "g_fill"));
    vecs.push_back(row(G, 1, 0, 0, 0, 16'd9, ex(16'd8, 16'd7, 4'd8, 0, 1, 1, 0), "g_push_full"));
    for (int k = 1; k <= 8; k++)
      vecs.push_back(row(G, 0, 1, 0, 0, 16'h0000,
                         ex(16'(8 - k), (k <= 6) ? 16'(7 - k) : 16'h0000, 4'(8 - k),
                            (k == 8), 1'b0, 1'b1, 1'b0), "g_drain"));
    vecs.push_back(row(G, 0, 1, 0, 0, 16'h0000, ex(16'h0000, 16'h0000, 4'd0, 1, 0, 1, 1), "g_pop_empty"));
    vecs.push_back(row(G, 0, 1, 0, 1, 16'h0000, ex(16'h0000, 16'h0000, 4'd0, 1, 0, 0, 1), "g_errclr_pop"));
    vecs.push_back(row(G, 0, 0, 0, 1, 16'h0000, ex(16'h0000, 16'h0000, 4'd0, 1, 0, 0, 0), "g_errclr"));
    vecs.push_back(row(G, 1, 1, 0, 0, 16'h5A5A, ex(16'h0000, 16'h0000, 4'd0, 1, 0, 0, 1), "g_repl_empty"));
    vecs.push_back(row(G, 1, 0, 0, 0, 16'h4444, ex(16'h4444, 16'h0000, 4'd1, 0, 0, 0, 1), "g_push_4"));
    vecs.push_back(row(G, 1, 1, 0, 0, 16'h5555, ex(16'h5555, 16'h0000, 4'd1, 0, 0, 0, 1), "g_repl_5"));
    vecs.push_back(row(G, 1, 0, 0, 0, 16'h6666, ex(16'h6666, 16'h5555, 4'd2, 0, 0, 0, 1), "g_push_6"));
    vecs.push_back(row(G, 0, 1, 0, 0, 16'h0000, ex(16'h5555, 16'h0000, 4'd1, 0, 0, 0, 1), "g_pop_low"));
    vecs.push_back(row(G, 0, 0, 0, 0, 16'h9999, ex(16'h5555, 16'h0000, 4'd1, 0, 0, 0, 1), "g_nop"));
    vecs.push_back(row(G, 0, 0, 0, 1, 16'h0000, ex(16'h5555, 16'h0000, 4'd1, 0, 0, 0, 0), "g_errclr2"));

    // ---------------- power-on reset ----------------
    #1 resetq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check(G, "reset_state", ex(16'h0000, 16'h0000, 4'd0, 1, 0, 0, 0));
    check(W, "reset_state", ex(16'h0000, 16'h0000, 4'd0, 1, 0, 0, 0));
    @(negedge clk);
    resetq = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].sel, vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].eclr, vecs[i].din);
      check(vecs[i].sel, vecs[i].name, vecs[i].exp);
    end

    // ---------------- asynchronous reset between edges at count 5 ----------------
    drive(W, 0, 0, 1, 0, 16'h0000);
    drive(G, 0, 0, 1, 0, 16'h0000);
    for (int i = 1; i <= 5; i++) begin
      drive(W, 1, 0, 0, 0, 16'h0100 + 16'(i));
      drive(G, 1, 0, 0, 0, 16'h0200 + 16'(i));
    end
    check(W, "pre_async_rst", ex(16'h0105, 16'h0104, 4'd5, 0, 0, 0, 0));
    check(G, "pre_async_rst", ex(16'h0205, 16'h0204, 4'd5, 0, 0, 0, 0));
    #2 resetq = 1'b0;
    #1;
    check(W, "async_rst", ex(16'h0000, 16'h0000, 4'd0, 1, 0, 0, 0));
    check(G, "async_rst", ex(16'h0000, 16'h0000, 4'd0, 1, 0, 0, 0));

    // ---------------- request on the releasing edge is ignored ----------------
    @(negedge clk);
    in_s[W]   = 16'h7777;
    push_s[W] = 1'b1;
    in_s[G]   = 16'h7777;
    push_s[G] = 1'b1;
    @(posedge clk);
    resetq = 1'b1;
    #1;
    idle_inputs();
    check(W, "rst_release_edge", ex(16'h0000, 16'h0000, 4'd0, 1, 0, 0, 0));
    check(G, "rst_release_edge", ex(16'h0000, 16'h0000, 4'd0, 1, 0, 0, 0));
    @(posedge clk);
    #1;
    check(W, "rst_release_idle", ex(16'h0000, 16'h0000, 4'd0, 1, 0, 0, 0));
    drive(W, 1, 0, 0, 0, 16'h8888);
    check(W, "first_op", ex(16'h8888, 16'h0000, 4'd1, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/checked_stack.md
CHECKED_STACK -- requirements
Module: checked_stack

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, the data word width in bits.
REQ-002 The block SHALL have parameter DEPTHLOG2, default 3, giving DEPTH = 2**DEPTHLOG2 entries.
REQ-003 The block SHALL have parameter WRAP, default 1: 1 = circular (J1-style) stack, 0 = guarded stack that blocks overflow/underflow.
REQ-004 The block SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 The block SHALL have port resetq  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port in  input  WIDTH  data to push or replace.
REQ-007 The block SHALL have port push  input  1  push request.
REQ-008 The block SHALL have port pop  input  1  pop request; push&pop together = replace top.
REQ-009 The block SHALL have port clr  input  1  synchronous flush: count to 0, sticky flags kept.
REQ-010 The block SHALL have port err_clr  input  1  synchronous clear of ovf and unf.
REQ-011 The block SHALL have port tos  output  WIDTH  registered top-of-stack.
REQ-012 The block SHALL have port nos  output  WIDTH  registered next-on-stack (entry below top).
REQ-013 The block SHALL have port count  output  DEPTHLOG2+1  registered occupancy, 0..DEPTH.
REQ-014 The block SHALL have ports empty, full  output  1  each: count==0, count==DEPTH.
REQ-015 The block SHALL have ports ovf, unf  output  1  each: sticky overflow/underflow flags.

Function
REQ-016 All outputs SHALL be registered; tos/nos/count/flags SHALL reflect the operation one cycle after the request edge.
REQ-017 Push when not full SHALL write in at index count, increment count, set tos=in, nos=old tos.
REQ-018 Pop when count>=1 SHALL decrement count, set tos=old nos, nos=entry at index count-3 (0 when count-3 < 0).
REQ-019 Replace (push&pop) with count>=1 SHALL overwrite the top entry with in, set tos=in, leave count and nos unchanged.
REQ-020 Replace with count==0 SHALL set unf; WRAP=0: no other state change; WRAP=1: write in at pointer-1 mod DEPTH, tos=in, count stays 0.
REQ-021 Push when full SHALL set ovf; WRAP=0: ignored; WRAP=1: overwrite oldest slot (pointer mod DEPTH), tos=in, count stays DEPTH.
REQ-022 Pop when empty SHALL set unf; WRAP=0: ignored, tos/nos hold; WRAP=1: pointer decrements mod DEPTH, tos/nos from the wrapped slots, count stays 0.
REQ-023 In WRAP=1 the internal pointer SHALL be DEPTHLOG2 bits and wrap modulo DEPTH; count SHALL saturate at 0 and DEPTH.
REQ-024 clr SHALL take priority over push/pop/replace; it SHALL set count=0, pointer=0, tos=nos=0, array contents untouched.
REQ-025 err_clr SHALL clear ovf/unf; a new error in the same cycle SHALL win (flag set).
REQ-026 With no request, all state SHALL hold.

Reset
REQ-027 On resetq low, count, pointer, tos, nos, ovf, unf SHALL clear to 0 immediately, independent of clk.
REQ-028 Array contents SHALL NOT be reset; reads of unwritten slots are don't-care except where REQ-018/024 force 0.
REQ-029 A request coinciding with the deasserting edge of resetq SHALL be ignored; first operation occurs on the following edge.
REQ-030 Assertion mid-operation SHALL abandon the in-flight request with no array write guaranteed.

Structure
REQ-031 A shared package SHALL hold the default WIDTH/DEPTHLOG2 constants and the opcode enum {NOP, PUSH, POP, REPL, CLR} decoded from clr/push/pop.
REQ-032 One sub-module, stack_ram (1 write, 2 async read ports, no reset), SHALL hold the array; pointer/flag logic stays in checked_stack.

Verification (WIDTH=16, DEPTHLOG2=3)
REQ-033 Reset, push 0x1111,0x2222,0x3333 -> tos=0x3333, nos=0x2222, count=3; pop -> tos=0x2222, nos=0x1111, count=2.
REQ-034 WRAP=0: 8 pushes 1..8 then push 9 -> full=1, ovf=1, tos=8, count=8; 8 pops then pop -> empty=1, unf=1, tos holds.
REQ-035 WRAP=1: 9 pushes 1..9 -> ovf=1, tos=9, nos=8, count=8; 8 pops -> last tos=9 (wrapped slot), count=0.
REQ-036 Push 0xAAAA, push 0xBBBB, replace 0xCCCC -> tos=0xCCCC, nos=0xAAAA, count=2; clr+push same cycle -> count=0, tos=0.
REQ-037 Set unf, then err_clr with a simultaneous empty pop -> unf stays 1; err_clr alone -> unf=0.
REQ-038 Drop resetq between clock edges at count=5 -> count, tos, nos, flags read 0 before next edge.
